// File: rtl/asi_pkg.sv
// Shared constants for the ASI user register block.
// Register indices, CTRL/STATUS bit positions and default ID.
package asi_pkg;

    localparam int IDX_CTRL    = 0;
    localparam int IDX_STATUS  = 1;
    localparam int IDX_TIMER   = 2;
    localparam int IDX_ID      = 3;
    localparam int IDX_SCRATCH = 4;

    localparam int CTRL_TIMER_EN = 0;
    localparam int CTRL_IRQ_EN   = 1;
    localparam int ST_EVT        = 0;
    localparam int ST_ADDR_ERR   = 1;

    localparam logic [31:0] REG_ID_DEF = 32'h4153_4901;

    function automatic logic [31:0] strb_mask(input logic [3:0] s);
        return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    endfunction

    function automatic logic [31:0] merge(
        input logic [31:0] old_v,
        input logic [31:0] new_v,
        input logic [31:0] mask
    );
        return (old_v & ~mask) | (new_v & mask);
    endfunction

endpackage

// File: rtl/asi_usr_regs_if.sv
// User-side register bus: shared write/read address, data and strobes.
// The master drives writes and addresses; the slave returns read data.
interface asi_usr_regs_if #(
    parameter int AXI_DW = 128,
    parameter int AXI_AW = 40
);
    logic [AXI_DW-1:0]   m_wdata;
    logic [AXI_DW/8-1:0] m_wstrb;
    logic                m_we;
    logic [AXI_AW-1:0]   m_addr;
    logic [AXI_DW-1:0]   m_rdata;

    modport master (
        output m_wdata, m_wstrb, m_we, m_addr,
        input  m_rdata
    );

    modport slave (
        input  m_wdata, m_wstrb, m_we, m_addr,
        output m_rdata
    );
endinterface

// File: rtl/asi_rd_pipe.sv
// Read-data delay line of DEPTH stages; DEPTH=0 is a pass-through.
// Output holds the last valid sample while no valid data emerges.
module asi_rd_pipe #(
    parameter int W     = 32,
    parameter int DEPTH = 2
) (
    input  logic         usr_clk,
    input  logic         usr_reset_n,
    input  logic         vld_i,
    input  logic [W-1:0] dat_i,
    output logic [W-1:0] dat_o
);
    logic         vld_l;
    logic [W-1:0] dat_l;
    logic [W-1:0] hold_q;

    generate
        if (DEPTH == 0) begin : g_pass
            assign vld_l = vld_i;
            assign dat_l = dat_i;
        end else begin : g_pipe
            logic [DEPTH-1:0] v_q;
            logic [W-1:0]     d_q [DEPTH];

            always_ff @(posedge usr_clk or negedge usr_reset_n) begin
                if (!usr_reset_n) begin
                    v_q <= '0;
                    for (int i = 0; i < DEPTH; i++) d_q[i] <= '0;
                end else begin
                    v_q[0] <= vld_i;
                    d_q[0] <= dat_i;
                    for (int i = 1; i < DEPTH; i++) begin
                        v_q[i] <= v_q[i-1];
                        d_q[i] <= d_q[i-1];
                    end
                end
            end

            assign vld_l = v_q[DEPTH-1];
            assign dat_l = d_q[DEPTH-1];
        end
    endgenerate

    always_ff @(posedge usr_clk or negedge usr_reset_n) begin
        if (!usr_reset_n) hold_q <= '0;
        else if (vld_l)   hold_q <= dat_l;
    end

    assign dat_o = vld_l ? dat_l : hold_q;

endmodule

// File: rtl/asi_usr_regs.sv
// User register file: CTRL, W1C STATUS, TIMER, ID, SCRATCH, delayed reads.
// Optional free-running timer built only with ASI_USR_REGS_TIMER_EN.
module asi_usr_regs
    import asi_pkg::*;
#(
    parameter int          AXI_DW  = 128,
    parameter int          AXI_AW  = 40,
    parameter int          SLV_WS  = 2,
    parameter int          REG_NUM = 16,
    parameter logic [31:0] REG_ID  = REG_ID_DEF
) (
    input  logic                 usr_clk,
    input  logic                 usr_reset_n,
    asi_usr_regs_if.slave        bus,
    input  logic                 evt_i,
    output logic                 irq,
    output logic [31:0]          ctrl_o
);
    localparam int LSB = $clog2(AXI_DW/8);
    localparam int IW  = $clog2(REG_NUM);

    logic [IW-1:0] idx;
    logic          oor;
    logic          wr_hit;
    logic [31:0]   wmask;
    logic [31:0]   wdat;
    logic          unused_bits;

    assign idx    = bus.m_addr[LSB +: IW];
    assign oor    = |bus.m_addr[AXI_AW-1:LSB+IW];
    assign wr_hit = bus.m_we & ~oor;
    assign wmask  = strb_mask(bus.m_wstrb[3:0]);
    assign wdat   = bus.m_wdata[31:0];

    assign unused_bits = ^{bus.m_addr[LSB-1:0],
                           bus.m_wdata[AXI_DW-1:32],
                           bus.m_wstrb[AXI_DW/8-1:4]};

    logic [31:0] ctrl_q, ctrl_d;
    logic [1:0]  status_q, status_d;
    logic        irq_q, irq_d;
    logic [31:0] scr_q [REG_NUM];
    logic [31:0] scr_d [REG_NUM];
    logic [31:0] tmr_val;
    logic [1:0]  st_clr;

    always_comb begin
        ctrl_d = ctrl_q;
        if (wr_hit && idx == IW'(IDX_CTRL))
            ctrl_d = merge(ctrl_q, wdat, wmask);
`ifndef ASI_USR_REGS_TIMER_EN
        ctrl_d[CTRL_TIMER_EN] = 1'b0;
`endif
    end

    // A same-cycle event set overrides a W1C clear of EVT.
    always_comb begin
        st_clr = 2'b00;
        if (wr_hit && idx == IW'(IDX_STATUS) && bus.m_wstrb[0])
            st_clr = wdat[1:0];
        status_d = status_q & ~st_clr;
        if (evt_i)             status_d[ST_EVT]      = 1'b1;
        if (bus.m_we && oor)   status_d[ST_ADDR_ERR] = 1'b1;
    end

    always_comb begin
        scr_d = scr_q;
        if (wr_hit && idx >= IW'(IDX_SCRATCH))
            scr_d[idx] = merge(scr_q[idx], wdat, wmask);
    end

    assign irq_d = status_q[ST_EVT] & ctrl_q[CTRL_IRQ_EN];

    always_ff @(posedge usr_clk or negedge usr_reset_n) begin
        if (!usr_reset_n) begin
            ctrl_q   <= '0;
            status_q <= '0;
            irq_q    <= 1'b0;
            for (int i = 0; i < REG_NUM; i++) scr_q[i] <= '0;
        end else begin
            ctrl_q   <= ctrl_d;
            status_q <= status_d;
            irq_q    <= irq_d;
            scr_q    <= scr_d;
        end
    end

`ifdef ASI_USR_REGS_TIMER_EN
    logic [31:0] timer_q, timer_d;

    assign timer_d = ctrl_q[CTRL_TIMER_EN] ? timer_q + 32'd1 : timer_q;

    always_ff @(posedge usr_clk or negedge usr_reset_n) begin
        if (!usr_reset_n) timer_q <= '0;
        else              timer_q <= timer_d;
    end

    assign tmr_val = timer_q;
`else
    assign tmr_val = '0;
`endif

    logic [31:0] rd_val;
    logic [31:0] rd_dat;

    always_comb begin
        rd_val = '0;
        if (!oor) begin
            unique case (1'b1)
                idx == IW'(IDX_CTRL):   rd_val = ctrl_q;
                idx == IW'(IDX_STATUS): rd_val = {30'd0, status_q};
                idx == IW'(IDX_TIMER):  rd_val = tmr_val;
                idx == IW'(IDX_ID):     rd_val = REG_ID;
                default:                rd_val = scr_q[idx];
            endcase
        end
    end

    asi_rd_pipe #(
        .W     (32),
        .DEPTH (SLV_WS)
    ) u_rd_pipe (
        .usr_clk     (usr_clk),
        .usr_reset_n (usr_reset_n),
        .vld_i       (~bus.m_we),
        .dat_i       (rd_val),
        .dat_o       (rd_dat)
    );

    assign bus.m_rdata = {{(AXI_DW-32){1'b0}}, rd_dat};
    assign irq         = irq_q;
    assign ctrl_o      = ctrl_q;

endmodule

// File: doc/asi_usr_regs.md
ASI_USR_REGS -- requirements
Module: asi_usr_regs

Interface
REQ-001 SHALL have parameter AXI_DW, default 128, user data-bus width in bits (multiple of 32).
REQ-002 SHALL have parameter AXI_AW, default 40, user address width.
REQ-003 SHALL have parameter SLV_WS, default 2, read latency in usr_clk cycles (0 = combinational).
REQ-004 SHALL have parameter REG_NUM, default 16, register count (power of two, at least 8).
REQ-005 SHALL have parameter REG_ID, default 32'h4153_4901, value returned by the ID register.
REQ-006 SHALL have port usr_clk, input, 1, user clock; all state is clocked by its rising edge.
REQ-007 SHALL have port usr_reset_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port m_wdata, input, AXI_DW, write data.
REQ-009 SHALL have port m_wstrb, input, AXI_DW/8, byte write enables.
REQ-010 SHALL have port m_we, input, 1, write strobe (one write per cycle).
REQ-011 SHALL have port m_addr, input, AXI_AW, byte address, shared by reads and writes.
REQ-012 SHALL have port m_rdata, output, AXI_DW, read data.
REQ-013 SHALL have port evt_i, input, 1, single-cycle event pulse.
REQ-014 SHALL have port irq, output, 1, level interrupt.
REQ-015 SHALL have port ctrl_o, output, 32, current CTRL register value.

Function
REQ-016 SHALL decode the register index as idx = m_addr[LSB +: log2(REG_NUM)], where LSB = log2(AXI_DW/8); addresses with any bit above the index field set are out-of-range.
REQ-017 SHALL make each register 32 bits wide, in bits [31:0] of the bus; bits [AXI_DW-1:32] read 0 and are ignored on write.
REQ-018 SHALL map the register file as follows:
- idx0: CTRL, RW, byte-strobed; bit0 = TIMER_EN, bit1 = IRQ_EN.
- idx1: STATUS, W1C; bit0 = EVT, bit1 = ADDR_ERR.
- idx2: TIMER, RO.
- idx3: ID, RO, REG_ID.
- idx4..REG_NUM-1: SCRATCH, RW, byte-strobed.
REQ-019 SHALL, when m_we=1, update only the bytes whose m_wstrb bit is 1.
REQ-020 SHALL ignore writes to RO registers.
REQ-021 SHALL, for an out-of-range write, leave all registers unchanged and set STATUS.ADDR_ERR.
REQ-022 SHALL sample m_addr every cycle in which m_we=0 and present the addressed value on m_rdata exactly SLV_WS cycles later.
REQ-023 SHALL hold m_rdata from the last read sample during cycles with m_we=1.
REQ-024 SHALL make reads side-effect free; an out-of-range read returns 0 and does not set ADDR_ERR.
REQ-025 SHALL make a read sampled in the cycle after a write return the written value.
REQ-026 SHALL set STATUS.EVT on evt_i=1; if the set and a W1C clear of the same bit occur in the same cycle, the set wins.
REQ-027 SHALL, with TIMER_EN=1, increment TIMER by 1 per cycle, wrapping 32'hFFFF_FFFF to 0; with TIMER_EN=0, TIMER holds its value.
REQ-028 SHALL drive irq = STATUS.EVT & CTRL.IRQ_EN, registered, so irq rises one cycle after the bit is set.
REQ-029 SHALL drive ctrl_o directly from the CTRL flop.

Reset
REQ-030 SHALL, while usr_reset_n=0, clear CTRL, STATUS, TIMER and SCRATCH, the read pipeline, m_rdata and irq to 0.
REQ-031 SHALL treat reset asserted mid-pipeline as discarding all in-flight reads.
REQ-032 SHALL, on the first edge after reset release, behave as the reset state with no spurious irq.

Configuration
REQ-033 SHALL honour macro ASI_USR_REGS_TIMER_EN: when defined, TIMER behaves per REQ-027; when undefined, the TIMER counter is not built, idx2 reads 0, and CTRL.TIMER_EN reads 0.

Structure
REQ-034 SHALL place the register index constants (CTRL/STATUS/TIMER/ID/SCRATCH base), the CTRL/STATUS bit positions and the default REG_ID in the shared package asi_pkg.
REQ-035 SHALL implement the SLV_WS-stage read-data delay line as sub-module asi_rd_pipe, with valid/data width parameterised and SLV_WS=0 meaning a pass-through.

Verification
REQ-036 SHALL cover write then read: write SCRATCH idx5 = 32'hDEAD_BEEF with m_wstrb=16'h000F, then read idx5 -> m_rdata[31:0]=32'hDEAD_BEEF exactly 2 cycles after the read sample (SLV_WS=2).
REQ-037 SHALL cover partial strobe: SCRATCH=32'h1122_3344, then write 32'hAABB_CCDD with m_wstrb=16'h0002 -> read returns 32'h1122_CC44.
REQ-038 SHALL cover set/clear collision: evt_i=1 in the same cycle as a STATUS write of 32'h1 -> EVT stays 1; with CTRL.IRQ_EN=1, irq=1 on the next cycle.
REQ-039 SHALL cover timer wrap: TIMER preloaded by force to 32'hFFFF_FFFE, TIMER_EN=1 -> reads 32'hFFFF_FFFF, then 0; with the macro undefined, idx2 reads 0.
REQ-040 SHALL cover out-of-range: write to address REG_NUM*16 -> ADDR_ERR=1 and no register changed; read of the same address -> 0; W1C of 32'h2 -> ADDR_ERR=0.
REQ-041 SHALL cover reset mid-operation: usr_reset_n asserted 1 cycle after a read sample -> m_rdata=0, CTRL=0, irq=0, and no stale data after release.
